// File: rtl/e_mult_div_unit_pkg.sv
// e_mult_div_unit_pkg: MD op codes, op width and default latencies shared with the hazard unit
package e_mult_div_unit_pkg;
  localparam int MD_OP_W = 4;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;
  typedef enum logic [MD_OP_W-1:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;
endpackage

// File: rtl/e_mult_div_unit_if.sv
// e_mult_div_unit_if: E-stage request/response bundle between pipeline and multiply/divide unit
interface e_mult_div_unit_if;
  import e_mult_div_unit_pkg::*;
  logic [MD_OP_W-1:0] E_MDOp;
  logic               E_Start;
  logic               E_Req;
  logic [31:0]        E_A;
  logic [31:0]        E_B;
  logic               E_Busy;
  logic [31:0]        E_MDOut;
  modport master (output E_MDOp, E_Start, E_Req, E_A, E_B, input E_Busy, E_MDOut);
  modport slave (input E_MDOp, E_Start, E_Req, E_A, E_B, output E_Busy, E_MDOut);
endinterface

// File: rtl/e_mult_div_unit_compute.sv
// e_mult_div_unit_compute: combinational {HI,LO} result for MULT/MULTU/DIV/DIVU
module e_mult_div_unit_compute
  import e_mult_div_unit_pkg::*;
(
  input  logic [MD_OP_W-1:0] op,
  input  logic [31:0]        a,
  input  logic [31:0]        b,
  output logic [63:0]        res,
  output logic               div_zero
);
  logic [63:0] prod_s, prod_u;
  logic [31:0] sbd, ubd, sq, sr, uq, ur;
  logic        ovf;
  // a safe divisor of 1 yields min_int/-1 -> q=0x80000000, r=0 for free
  always_comb begin
    prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prod_u = {32'b0, a} * {32'b0, b};
    div_zero = b == '0;
    ovf = a == 32'h8000_0000 && b == '1;
    sbd = div_zero || ovf ? 32'd1 : b;
    ubd = div_zero ? 32'd1 : b;
    sq = $signed(a) / $signed(sbd);
    sr = $signed(a) % $signed(sbd);
    uq = a / ubd;
    ur = a % ubd;
    res = op == MD_MULT  ? prod_s :
          op == MD_MULTU ? prod_u :
          op == MD_DIV   ? {sr, sq} :
          op == MD_DIVU  ? {ur, uq} : '0;
  end
endmodule

// File: rtl/e_mult_div_unit.sv
// e_mult_div_unit: E-stage HI/LO owner with busy-counter latency for multiply/divide
module e_mult_div_unit
  import e_mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input logic              clk,
  input logic              reset,
  e_mult_div_unit_if.slave md
);
  localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
  logic [CW-1:0] cnt, cnt_nxt;
  logic [31:0]   hi, lo, tmp_hi, tmp_lo, hi_nxt, lo_nxt, tmp_hi_nxt, tmp_lo_nxt;
  logic          tmp_ok, tmp_ok_nxt, idle, accept, is_div, commit, div_zero;
  logic [63:0]   res;
  e_mult_div_unit_compute u_compute (
    .op(md.E_MDOp),
    .a(md.E_A),
    .b(md.E_B),
    .res(res),
    .div_zero(div_zero)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      tmp_hi <= '0;
      tmp_lo <= '0;
      tmp_ok <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      hi <= hi_nxt;
      lo <= lo_nxt;
      tmp_hi <= tmp_hi_nxt;
      tmp_lo <= tmp_lo_nxt;
      tmp_ok <= tmp_ok_nxt;
    end
  end
  // a divide by zero still burns its cycles but never commits
  always_comb begin
    idle = cnt == '0;
    accept = md.E_Start && !md.E_Req && idle;
    is_div = md.E_MDOp == MD_DIV || md.E_MDOp == MD_DIVU;
    commit = cnt == CW'(1);
    cnt_nxt = accept ? (is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES)) : idle ? cnt : cnt - CW'(1);
    tmp_hi_nxt = accept ? res[63:32] : tmp_hi;
    tmp_lo_nxt = accept ? res[31:0] : tmp_lo;
    tmp_ok_nxt = accept ? !(is_div && div_zero) : tmp_ok;
    hi_nxt = commit && tmp_ok ? tmp_hi : idle && !md.E_Req && md.E_MDOp == MD_MTHI ? md.E_A : hi;
    lo_nxt = commit && tmp_ok ? tmp_lo : idle && !md.E_Req && md.E_MDOp == MD_MTLO ? md.E_A : lo;
  end
  always_comb begin
    md.E_Busy = cnt != '0;
    md.E_MDOut = md.E_MDOp == MD_MFHI ? hi : md.E_MDOp == MD_MFLO ? lo : '0;
  end
endmodule

// File: tb/tb_e_mult_div_unit.sv
// tb_e_mult_div_unit: directed scoreboard bench for the E-stage multiply/divide unit
module tb_e_mult_div_unit;
  import e_mult_div_unit_pkg::*;
  typedef struct packed {logic [31:0] hi; logic [31:0] lo;} exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  exp_t q[$];
  logic [31:0] rh, rl, mdl_hi, mdl_lo;
  e_mult_div_unit_if md ();
  e_mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .md(md));
  initial forever #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic st, input logic rq, input logic [31:0] a, input logic [31:0] b);
    md.E_MDOp = op;
    md.E_Start = st;
    md.E_Req = rq;
    md.E_A = a;
    md.E_B = b;
  endtask

  task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
    md.E_MDOp = MD_MFHI;
    #1 h = md.E_MDOut;
    md.E_MDOp = MD_MFLO;
    #1 l = md.E_MDOut;
    md.E_MDOp = MD_NONE;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (md.E_Busy === 1'b1 && n < 64) begin
      n++;
      step();
    end
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_queue got=empty exp=entry", tag);
    end else begin
      e = q.pop_front();
      read_hilo(rh, rl);
      chk({tag, "_hi"}, rh, e.hi);
      chk({tag, "_lo"}, rl, e.lo);
      mdl_hi = e.hi;
      mdl_lo = e.lo;
    end
  endtask

  task automatic run_md(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int cyc, input logic [31:0] eh, input logic [31:0] el);
    int n;
    q.push_back('{eh, el});
    drive(op, 1'b1, 1'b0, a, b);
    step();
    drive(MD_NONE, 1'b0, 1'b0, 32'h0, 32'h0);
    count_busy(n);
    chk({tag, "_busy_cycles"}, 32'(n), 32'(cyc));
    pop_cmp(tag);
  endtask

  initial begin
    int n;
    drive(MD_NONE, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    step();
    reset = 1'b0;
    chk("reset_busy", {31'b0, md.E_Busy}, 32'h0);
    read_hilo(rh, rl);
    chk("reset_hi", rh, 32'h0);
    chk("reset_lo", rl, 32'h0);
    run_md("mult", MD_MULT, 32'hFFFF_FFFD, 32'd5, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_md("divu", MD_DIVU, 32'd7, 32'd2, 10, 32'd1, 32'd3);
    run_md("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    drive(MD_MTHI, 1'b0, 1'b0, 32'h1234_5678, 32'h0);
    step();
    drive(MD_MTLO, 1'b0, 1'b0, 32'h9ABC_DEF0, 32'h0);
    step();
    run_md("div0", MD_DIV, 32'd100, 32'd0, 10, 32'h1234_5678, 32'h9ABC_DEF0);
    drive(MD_MULTU, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step();
    drive(MD_NONE, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("req_start_busy", {31'b0, md.E_Busy}, 32'h0);
    step();
    step();
    read_hilo(rh, rl);
    chk("req_start_hi", rh, mdl_hi);
    chk("req_start_lo", rl, mdl_lo);
    drive(MD_MTLO, 1'b0, 1'b1, 32'h5555_5555, 32'h0);
    step();
    drive(MD_NONE, 1'b0, 1'b0, 32'h0, 32'h0);
    read_hilo(rh, rl);
    chk("req_mtlo_lo", rl, mdl_lo);
    run_md("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000);
    run_md("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);
    drive(MD_MULT, 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
    step();
    drive(MD_NONE, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_mid_busy", {31'b0, md.E_Busy}, 32'h0);
    read_hilo(rh, rl);
    chk("rst_mid_hi", rh, 32'h0);
    chk("rst_mid_lo", rl, 32'h0);
    repeat (6) step();
    chk("rst_late_busy", {31'b0, md.E_Busy}, 32'h0);
    read_hilo(rh, rl);
    chk("rst_late_hi", rh, 32'h0);
    chk("rst_late_lo", rl, 32'h0);
    q.push_back('{32'h1, 32'h0});
    drive(MD_MULT, 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
    step();
    drive(MD_NONE, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    drive(MD_DIVU, 1'b1, 1'b0, 32'd100, 32'd7);
    step();
    drive(MD_MTHI, 1'b0, 1'b0, 32'h0000_DEAD, 32'h0);
    step();
    drive(MD_NONE, 1'b0, 1'b0, 32'h0, 32'h0);
    read_hilo(rh, rl);
    chk("busy_mthi_ignored", rh, 32'h0);
    chk("busy_still_high", {31'b0, md.E_Busy}, 32'h1);
    count_busy(n);
    chk("busy_extra_cycles", 32'(n), 32'd2);
    pop_cmp("busy_ignore");
    step();
    chk("busy_ignore_idle", {31'b0, md.E_Busy}, 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
